mc6502_interrupt_sequencer: RTL

- Interrupt and reset sequencer for the MC6502 core. It sits directly upstream of the processor status register.
- Arbitrates RESET, NMI, IRQ and BRK, and steps the 7-cycle stack/vector sequence.
- Produces the stacked status byte and drives the I/B flag-update strobes into the status register.
- Consumes the status register's output (I flag) to qualify IRQ.

---
 rtl/mc6502_interrupt_sequencer_if.sv | 38 +++
 rtl/mc6502_interrupt_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mc6502_interrupt_sequencer_if.sv
`default_nettype none
// ============================================================================
// mc6502_interrupt_sequencer_if : request/status/stack/vector bundle between core and sequencer
// Revision 1.0
// ============================================================================
interface mc6502_interrupt_sequencer_if;
    logic        cen;
    logic        i_nmi_x;
    logic        i_irq_x;
    logic [7:0]  i_psr;
    logic        i_sync;
    logic        i_brk;
    logic        o_busy;
    logic [2:0]  o_step;
    logic        o_stk_wr;
    logic [1:0]  o_stk_sel;
    logic [7:0]  o_push_p;
    logic        o_vec_rd;
    logic [15:0] o_vec_addr;
    logic        o_set_i;
    logic        o_i;
    logic        o_set_b;
    logic        o_b;
    logic        o_done;

    modport master (
        output cen, i_nmi_x, i_irq_x, i_psr, i_sync, i_brk,
        input  o_busy, o_step, o_stk_wr, o_stk_sel, o_push_p, o_vec_rd,
               o_vec_addr, o_set_i, o_i, o_set_b, o_b, o_done
    );

    modport slave (
        input  cen, i_nmi_x, i_irq_x, i_psr, i_sync, i_brk,
        output o_busy, o_step, o_stk_wr, o_stk_sel, o_push_p, o_vec_rd,
               o_vec_addr, o_set_i, o_i, o_set_b, o_b, o_done
    );
endinterface
`default_nettype wire

// File: rtl/mc6502_interrupt_sequencer.sv
`default_nettype none
// ============================================================================
// mc6502_interrupt_sequencer : RESET/NMI/IRQ/BRK arbitration and 7-step stack/vector sequence
// Revision 1.0
// ============================================================================
module mc6502_interrupt_sequencer #(
    parameter logic [15:0] VEC_NMI = 16'hFFFA,
    parameter logic [15:0] VEC_RST = 16'hFFFC,
    parameter logic [15:0] VEC_IRQ = 16'hFFFE
) (
    input  logic                          clk,
    input  logic                          rst_x,
    mc6502_interrupt_sequencer_if.slave   bus
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_PCH = 4'd3, S_PCL = 4'd4,
        S_PSH  = 4'd5, S_VL = 4'd6, S_VH = 4'd7, S_HOLD = 4'd8
    } state_t;

    typedef enum logic [1:0] {K_RESET = 2'd0, K_NMI = 2'd1, K_IRQ = 2'd2, K_BRK = 2'd3} kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [15:0] base_q, base_d;
    logic        nmi_dly_q, nmi_pend_q, nmi_pend_d;
    logic        w_irq_req, w_nmi_edge;

    logic        busy_q, busy_d, stk_wr_q, stk_wr_d, vec_rd_q, vec_rd_d, done_q, done_d;
    logic        psh_q, psh_d, b_q, b_d;
    logic [2:0]  step_q, step_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] vec_addr_q, vec_addr_d;

    logic        w_unused_psr;
    assign w_unused_psr = ^bus.i_psr[5:4];

    function automatic logic [15:0] kind_base(input kind_t k);
        case (k)
            K_RESET: kind_base = VEC_RST;
            K_NMI:   kind_base = VEC_NMI;
            default: kind_base = VEC_IRQ;
        endcase
    endfunction

    assign w_irq_req  = !bus.i_irq_x && !bus.i_psr[2];
    assign w_nmi_edge = nmi_dly_q && !bus.i_nmi_x;

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        base_d     = base_q;
        nmi_pend_d = nmi_pend_q;
        if (bus.cen) begin
            case (state_q)
                S_HOLD: begin
                    state_d = S_T1;
                    kind_d  = K_RESET;
                end
                S_IDLE: begin
                    if (bus.i_sync && (nmi_pend_q || w_irq_req)) begin
                        state_d = S_T1;
                        kind_d  = nmi_pend_q ? K_NMI : K_IRQ;
                    end else if (bus.i_brk) begin
                        state_d = S_T2;
                        kind_d  = K_BRK;
                    end
                end
                S_T1:  state_d = S_T2;
                S_T2:  state_d = S_PCH;
                S_PCH: state_d = S_PCL;
                S_PCL: state_d = S_PSH;
                S_PSH: begin
                    // A pending NMI hijacks IRQ/BRK after P is already stacked
                    state_d = S_VL;
                    if (kind_q == K_RESET) begin
                        base_d = VEC_RST;
                    end else if (kind_q == K_NMI || nmi_pend_q) begin
                        base_d     = VEC_NMI;
                        nmi_pend_d = 1'b0;
                    end else begin
                        base_d = VEC_IRQ;
                    end
                end
                S_VL:    state_d = S_VH;
                S_VH:    state_d = S_IDLE;
                default: state_d = S_HOLD;
            endcase
            if (w_nmi_edge) nmi_pend_d = 1'b1;
        end
    end

    always_comb begin
        busy_d     = (state_d != S_IDLE) && (state_d != S_HOLD);
        step_d     = (state_d == S_HOLD) ? 3'd0 : state_d[2:0];
        stk_wr_d   = (state_d == S_PCH || state_d == S_PCL || state_d == S_PSH) && (kind_d != K_RESET);
        sel_d      = (state_d == S_PCL) ? 2'd1 : (state_d == S_PSH) ? 2'd2 : 2'd0;
        vec_rd_d   = (state_d == S_VL) || (state_d == S_VH);
        done_d     = (state_d == S_VH);
        psh_d      = (state_d == S_PSH);
        b_d        = (state_d == S_PSH) && (kind_d == K_BRK);
        vec_addr_d = (state_d == S_VL) ? base_d :
                     (state_d == S_VH) ? base_d + 16'd1 : kind_base(kind_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            state_q    <= S_HOLD;
            kind_q     <= K_RESET;
            base_q     <= VEC_RST;
            nmi_pend_q <= 1'b0;
            nmi_dly_q  <= 1'b1;
            busy_q     <= 1'b0;
            step_q     <= 3'd0;
            stk_wr_q   <= 1'b0;
            sel_q      <= 2'd0;
            vec_rd_q   <= 1'b0;
            done_q     <= 1'b0;
            psh_q      <= 1'b0;
            b_q        <= 1'b0;
            vec_addr_q <= VEC_RST;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            base_q     <= base_d;
            nmi_pend_q <= nmi_pend_d;
            if (bus.cen) nmi_dly_q <= bus.i_nmi_x;
            busy_q     <= busy_d;
            step_q     <= step_d;
            stk_wr_q   <= stk_wr_d;
            sel_q      <= sel_d;
            vec_rd_q   <= vec_rd_d;
            done_q     <= done_d;
            psh_q      <= psh_d;
            b_q        <= b_d;
            vec_addr_q <= vec_addr_d;
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_step     = step_q;
    assign bus.o_stk_wr   = stk_wr_q;
    assign bus.o_stk_sel  = sel_q;
    assign bus.o_vec_rd   = vec_rd_q;
    assign bus.o_vec_addr = vec_addr_q;
    assign bus.o_done     = done_q;
    assign bus.o_set_i    = psh_q;
    assign bus.o_i        = psh_q;
    assign bus.o_set_b    = psh_q;
    assign bus.o_b        = b_q;
    assign bus.o_push_p   = {bus.i_psr[7:6], 1'b1, kind_q == K_BRK, bus.i_psr[3:0]};

endmodule
`default_nettype wire
